control_sequencer: RTL

// - Multi-cycle fetch/decode/execute FSM for the 8-bit CPU.
// - Drives the load enables of every datapath register (PC, MAR, IR, A, B, FLAGS, OUT)
//   and the single-driver bus output selects.
// - Takes the opcode from the IR output and the C/Z flags from the flags register.
// - Sits directly upstream of the register instances: its *_load outputs feed their enable pins.

---
 rtl/cpu_pkg.sv | 158 +++++++++++++++
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 48 ++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: widths, state encoding,
// opcodes, the control strobe bundle and the sequencer decode function.
package cpu_pkg;

    localparam int STATE_W  = 3;
    localparam int OPCODE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_out;
        logic ram_we;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic flags_load;
        logic out_load;
    } ctrl_t;

    typedef struct packed {
        state_t next;
        ctrl_t  ctrl;
    } step_t;

    // Undefined opcodes 0x9-0xD are folded onto NOP or HLT.
    function automatic logic [OPCODE_W-1:0] effective_op(
        input logic [OPCODE_W-1:0] op,
        input logic                halt_on_illegal
    );
        logic [OPCODE_W-1:0] r;
        r = op;
        case (op)
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD: r = halt_on_illegal ? OP_HLT : OP_NOP;
            default: r = op;
        endcase
        return r;
    endfunction

    // Next state and control strobes for one cycle; outputs depend only on the
    // current state plus opcode/flags, so one decode serves both.
    function automatic step_t sequence_step(
        input state_t              st,
        input logic [OPCODE_W-1:0] op,
        input logic                c,
        input logic                z,
        input logic                run
    );
        step_t  s;
        state_t boundary;
        s        = '0;
        s.next   = st;
        boundary = run ? ST_T0 : ST_IDLE;
        case (st)
            ST_IDLE: s.next = run ? ST_T0 : ST_IDLE;
            ST_T0: begin
                s.ctrl.pc_out   = 1'b1;
                s.ctrl.mar_load = 1'b1;
                s.next          = ST_T1;
            end
            ST_T1: begin
                s.ctrl.ram_out = 1'b1;
                s.ctrl.ir_load = 1'b1;
                s.ctrl.pc_inc  = 1'b1;
                s.next         = ST_T2;
            end
            ST_T2: begin
                s.next = boundary;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        s.ctrl.ir_out   = 1'b1;
                        s.ctrl.mar_load = 1'b1;
                        s.next          = ST_T3;
                    end
                    OP_LDI: begin
                        s.ctrl.ir_out = 1'b1;
                        s.ctrl.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        s.ctrl.ir_out  = 1'b1;
                        s.ctrl.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        s.ctrl.ir_out  = c;
                        s.ctrl.pc_load = c;
                    end
                    OP_JZ: begin
                        s.ctrl.ir_out  = z;
                        s.ctrl.pc_load = z;
                    end
                    OP_OUT: begin
                        s.ctrl.a_out    = 1'b1;
                        s.ctrl.out_load = 1'b1;
                    end
                    OP_HLT: s.next = ST_HALT;
                    default: s.next = boundary;
                endcase
            end
            ST_T3: begin
                s.next = boundary;
                case (op)
                    OP_LDA: begin
                        s.ctrl.ram_out = 1'b1;
                        s.ctrl.a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        s.ctrl.ram_out = 1'b1;
                        s.ctrl.b_load  = 1'b1;
                        s.next         = ST_T4;
                    end
                    OP_STA: begin
                        s.ctrl.a_out  = 1'b1;
                        s.ctrl.ram_we = 1'b1;
                    end
                    default: s.next = boundary;
                endcase
            end
            ST_T4: begin
                s.ctrl.alu_out    = 1'b1;
                s.ctrl.a_load     = 1'b1;
                s.ctrl.flags_load = 1'b1;
                s.ctrl.alu_sub    = (op == OP_SUB);
                s.next            = boundary;
            end
            ST_HALT: s.next = ST_HALT;
            default: s.next = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    import cpu_pkg::*;

    logic                run;
    logic [OPCODE_W-1:0] ir_opcode;
    logic                flag_c;
    logic                flag_z;

    logic pc_out, pc_inc, pc_load;
    logic mar_load;
    logic ram_out, ram_we;
    logic ir_load, ir_out;
    logic a_load, a_out, b_load;
    logic alu_out, alu_sub, flags_load;
    logic out_load;
    logic halted;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  run, ir_opcode, flag_c, flag_z,
        output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_we,
               ir_load, ir_out, a_load, a_out, b_load,
               alu_out, alu_sub, flags_load, out_load, halted, state_o
    );

    modport slave (
        output run, ir_opcode, flag_c, flag_z,
        input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_we,
               ir_load, ir_out, a_load, a_out, b_load,
               alu_out, alu_sub, flags_load, out_load, halted, state_o
    );

endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit CPU. Strobes are decoded
// combinationally from the state register so an asynchronous reset removes
// them immediately, before any further clock edge.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);

    state_t state;
    step_t  step;

    // Decode next state and strobes from the current state and IR/flags.
    always_comb begin
        step = sequence_step(state,
                             effective_op(bus.ir_opcode, HALT_ON_ILLEGAL),
                             bus.flag_c, bus.flag_z, bus.run);
    end

    // State register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= step.next;
    end

    assign bus.pc_out     = step.ctrl.pc_out;
    assign bus.pc_inc     = step.ctrl.pc_inc;
    assign bus.pc_load    = step.ctrl.pc_load;
    assign bus.mar_load   = step.ctrl.mar_load;
    assign bus.ram_out    = step.ctrl.ram_out;
    assign bus.ram_we     = step.ctrl.ram_we;
    assign bus.ir_load    = step.ctrl.ir_load;
    assign bus.ir_out     = step.ctrl.ir_out;
    assign bus.a_load     = step.ctrl.a_load;
    assign bus.a_out      = step.ctrl.a_out;
    assign bus.b_load     = step.ctrl.b_load;
    assign bus.alu_out    = step.ctrl.alu_out;
    assign bus.alu_sub    = step.ctrl.alu_sub;
    assign bus.flags_load = step.ctrl.flags_load;
    assign bus.out_load   = step.ctrl.out_load;
    assign bus.halted     = (state == ST_HALT);
    assign bus.state_o    = state;

endmodule
